// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter: requester indices,
// arbiter state encoding and SRAM word/address types.
package sram_arb_pkg;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] REQ_VGA  = 2'd0;
    localparam logic [1:0] REQ_DEC  = 2'd1;
    localparam logic [1:0] REQ_UART = 2'd2;

    typedef logic [17:0] sram_addr_t;
    typedef logic [15:0] sram_data_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_LOCKED = 2'd2
    } arb_state_type;

    function automatic logic [2:0] req_onehot(input logic [1:0] idx);
        logic [2:0] v;
        v = 3'b000;
        case (idx)
            REQ_VGA:  v = 3'b001;
            REQ_DEC:  v = 3'b010;
            REQ_UART: v = 3'b100;
            default:  v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester-side bus of the SRAM access arbiter: per-requester request,
// lock, access fields, and the grant / read-return signals.
interface sram_access_arbiter_if;
    import sram_arb_pkg::*;

    logic [2:0]               req_I;
    logic [2:0]               lock_I;
    logic [2:0]               we_n_I;
    sram_addr_t [2:0]         address_I;
    sram_data_t [2:0]         write_data_I;
    logic [2:0]               gnt_O;
    logic [2:0]               rdata_valid_O;
    sram_data_t               read_data_O;

    modport master (
        output req_I, lock_I, we_n_I, address_I, write_data_I,
        input  gnt_O, rdata_valid_O, read_data_O
    );

    modport slave (
        input  req_I, lock_I, we_n_I, address_I, write_data_I,
        output gnt_O, rdata_valid_O, read_data_O
    );

endinterface

// File: rtl/sram_read_tag_pipe.sv
// One-hot read-owner tag shift register; the tail lines up with the cycle in
// which the SRAM read data for that access is valid.
module sram_read_tag_pipe #(
    parameter int READ_LATENCY = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_tag,
    output logic [2:0] o_tag,
    output logic       o_busy
);

    logic [READ_LATENCY:0][2:0] r_stages;

    // Shift the read tag one stage per cycle; reset drops everything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stages <= '0;
        end else begin
            r_stages <= {r_stages[READ_LATENCY-1:0], i_tag};
        end
    end

    assign o_tag  = r_stages[READ_LATENCY];
    assign o_busy = |r_stages;

endmodule

// File: rtl/sram_access_arbiter.sv
// Per-cycle arbiter sharing one SRAM port between VGA, decoder and UART with
// bounded lock bursts. Optional statistics counters: define SRAM_ARB_STATS_EN.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 3,
    parameter int MAX_BURST    = 8
) (
    input  logic                   Clock_50,
    input  logic                   Resetn,
    sram_access_arbiter_if.slave   bus,
    output sram_addr_t             SRAM_address_O,
    output sram_data_t             SRAM_write_data_O,
    output logic                   SRAM_we_n_O,
    input  sram_data_t             SRAM_read_data_I,
    output logic                   busy_O
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_type    r_state;
    logic [1:0]       r_owner;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_rr_uart;
    sram_addr_t       r_sram_addr;
    sram_data_t       r_sram_wdata;
    logic             r_sram_we_n;

    logic             w_continue;
    logic             w_any_gnt;
    logic [1:0]       w_gnt_idx;
    logic [2:0]       w_gnt;
    logic [2:0]       w_rd_tag;
    logic [2:0]       w_tag_tail;
    logic             w_pipe_busy;

    // Grant selection: locked owner first, then VGA, then decoder/UART round-robin.
    always_comb begin
        w_any_gnt  = 1'b0;
        w_gnt_idx  = REQ_VGA;
        w_continue = (r_state == S_LOCKED) && bus.req_I[r_owner] &&
                     bus.lock_I[r_owner] && (r_burst_cnt < MAX_CNT);
        if (!Resetn) begin
            w_any_gnt = 1'b0;
        end else if (w_continue) begin
            w_any_gnt = 1'b1;
            w_gnt_idx = r_owner;
        end else if (bus.req_I[REQ_VGA]) begin
            w_any_gnt = 1'b1;
            w_gnt_idx = REQ_VGA;
        end else if (bus.req_I[REQ_DEC] && bus.req_I[REQ_UART]) begin
            w_any_gnt = 1'b1;
            w_gnt_idx = r_rr_uart ? REQ_UART : REQ_DEC;
        end else if (bus.req_I[REQ_DEC]) begin
            w_any_gnt = 1'b1;
            w_gnt_idx = REQ_DEC;
        end else if (bus.req_I[REQ_UART]) begin
            w_any_gnt = 1'b1;
            w_gnt_idx = REQ_UART;
        end else begin
            w_any_gnt = 1'b0;
        end
    end

    assign w_gnt    = w_any_gnt ? req_onehot(w_gnt_idx) : 3'b000;
    assign w_rd_tag = (w_any_gnt && bus.we_n_I[w_gnt_idx]) ? w_gnt : 3'b000;

    // Arbiter FSM plus registered SRAM command. The round-robin pointer always
    // points away from the last non-VGA winner, so a finished burst owner loses ties.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state      <= S_IDLE;
            r_owner      <= REQ_VGA;
            r_burst_cnt  <= '0;
            r_rr_uart    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_sram_we_n  <= 1'b1;
        end else if (w_any_gnt) begin
            r_owner      <= w_gnt_idx;
            r_sram_addr  <= bus.address_I[w_gnt_idx];
            r_sram_wdata <= bus.write_data_I[w_gnt_idx];
            r_sram_we_n  <= bus.we_n_I[w_gnt_idx];
            if (w_gnt_idx != REQ_VGA) begin
                r_rr_uart <= (w_gnt_idx == REQ_DEC);
            end else begin
                r_rr_uart <= r_rr_uart;
            end
            if (bus.lock_I[w_gnt_idx]) begin
                r_state     <= S_LOCKED;
                r_burst_cnt <= w_continue ? (r_burst_cnt + CNT_ONE) : CNT_ONE;
            end else begin
                r_state     <= S_GRANT;
                r_burst_cnt <= '0;
            end
        end else begin
            r_state     <= S_IDLE;
            r_burst_cnt <= '0;
            r_sram_we_n <= 1'b1;
        end
    end

    sram_read_tag_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tag_pipe (
        .i_clk   (Clock_50),
        .i_rst_n (Resetn),
        .i_tag   (w_rd_tag),
        .o_tag   (w_tag_tail),
        .o_busy  (w_pipe_busy)
    );

    assign bus.gnt_O         = w_gnt;
    assign bus.rdata_valid_O = w_tag_tail;
    assign bus.read_data_O   = SRAM_read_data_I;
    assign SRAM_address_O    = r_sram_addr;
    assign SRAM_write_data_O = r_sram_wdata;
    assign SRAM_we_n_O       = r_sram_we_n;
    assign busy_O            = (|w_gnt) | w_pipe_busy;

`ifdef SRAM_ARB_STATS_EN
    logic [2:0][31:0] r_grant_cnt;
    logic [15:0]      r_vga_wait;
    logic [15:0]      r_vga_max_wait;

    // Saturating grant counters and longest VGA wait without a grant.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_grant_cnt    <= '0;
            r_vga_wait     <= 16'd0;
            r_vga_max_wait <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt[i] && (r_grant_cnt[i] != 32'hFFFF_FFFF)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
                end else begin
                    r_grant_cnt[i] <= r_grant_cnt[i];
                end
            end
            if (bus.req_I[REQ_VGA] && !w_gnt[REQ_VGA]) begin
                if (r_vga_wait != 16'hFFFF) begin
                    r_vga_wait <= r_vga_wait + 16'd1;
                    if ((r_vga_wait + 16'd1) > r_vga_max_wait) begin
                        r_vga_max_wait <= r_vga_wait + 16'd1;
                    end else begin
                        r_vga_max_wait <= r_vga_max_wait;
                    end
                end else begin
                    r_vga_wait <= r_vga_wait;
                end
            end else begin
                r_vga_wait <= 16'd0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed self-checking bench for sram_access_arbiter.
module tb_sram_access_arbiter;
    import sram_arb_pkg::*;

    logic       clk;
    logic       rst_n;
    sram_addr_t sram_addr;
    sram_data_t sram_wdata;
    logic       sram_we_n;
    sram_data_t sram_rdata;
    logic       busy;
    int         tests_run;
    int         tests_failed;

    sram_access_arbiter_if bus ();

    sram_access_arbiter #(
        .READ_LATENCY (3),
        .MAX_BURST    (8)
    ) dut (
        .Clock_50          (clk),
        .Resetn            (rst_n),
        .bus               (bus),
        .SRAM_address_O    (sram_addr),
        .SRAM_write_data_O (sram_wdata),
        .SRAM_we_n_O       (sram_we_n),
        .SRAM_read_data_I  (sram_rdata),
        .busy_O            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req_I = 3'b111;
        step;
        step;
        #4;
        tests_run++; if (bus.gnt_O !== 3'b000) begin tests_failed++; $display("FAIL reset_gnt got %b want 000", bus.gnt_O); end
        tests_run++; if (bus.rdata_valid_O !== 3'b000) begin tests_failed++; $display("FAIL reset_rvalid got %b want 000", bus.rdata_valid_O); end
        tests_run++; if (sram_we_n !== 1'b1) begin tests_failed++; $display("FAIL reset_we_n got %b want 1", sram_we_n); end
        tests_run++; if (sram_addr !== 18'h00000) begin tests_failed++; $display("FAIL reset_addr got %h want 00000", sram_addr); end
        tests_run++; if (sram_wdata !== 16'h0000) begin tests_failed++; $display("FAIL reset_wdata got %h want 0000", sram_wdata); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        step;
        rst_n = 1'b1;
        #4;
        tests_run++; if (bus.gnt_O !== 3'b001) begin tests_failed++; $display("FAIL post_reset_gnt got %b want 001", bus.gnt_O); end
        bus.req_I = 3'b000;
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_seq [6];
        exp_seq = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100};
        step;
        bus.req_I  = 3'b110;
        bus.we_n_I = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #4;
            tests_run++; if (bus.gnt_O !== exp_seq[i]) begin tests_failed++; $display("FAIL rr_gnt[%0d] got %b want %b", i, bus.gnt_O, exp_seq[i]); end
            step;
        end
        bus.req_I = 3'b000;
        repeat (6) step;
    endtask

    task automatic test_read_latency;
        bus.req_I        = 3'b010;
        bus.we_n_I       = 3'b111;
        bus.address_I[1] = 18'h00100;
        sram_rdata       = 16'hBEEF;
        #4;
        tests_run++; if (bus.gnt_O !== 3'b010) begin tests_failed++; $display("FAIL rd_gnt got %b want 010", bus.gnt_O); end
        step;
        bus.req_I = 3'b000;
        for (int k = 1; k <= 5; k++) begin
            #4;
            tests_run++;
            if (bus.rdata_valid_O !== ((k == 4) ? 3'b010 : 3'b000)) begin
                tests_failed++; $display("FAIL rd_rvalid[N+%0d] got %b want %b", k, bus.rdata_valid_O, (k == 4) ? 3'b010 : 3'b000);
            end
            if (k == 1) begin
                tests_run++; if (sram_addr !== 18'h00100) begin tests_failed++; $display("FAIL rd_addr got %h want 00100", sram_addr); end
                tests_run++; if (sram_we_n !== 1'b1) begin tests_failed++; $display("FAIL rd_we_n got %b want 1", sram_we_n); end
            end
            if (k == 2) begin
                tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rd_busy got %b want 1", busy); end
            end
            if (k == 4) begin
                tests_run++; if (bus.read_data_O !== 16'hBEEF) begin tests_failed++; $display("FAIL rd_data got %h want BEEF", bus.read_data_O); end
            end
            step;
        end
        sram_rdata = 16'h0000;
    endtask

    task automatic test_lock_burst;
        bus.req_I  = 3'b010;
        bus.lock_I = 3'b010;
        bus.we_n_I = 3'b000;
        for (int c = 1; c <= 9; c++) begin
            #4;
            tests_run++;
            if (bus.gnt_O !== ((c == 9) ? 3'b001 : 3'b010)) begin
                tests_failed++; $display("FAIL burst_gnt[%0d] got %b want %b", c, bus.gnt_O, (c == 9) ? 3'b001 : 3'b010);
            end
            step;
            if (c == 1) bus.req_I = 3'b011;
        end
        bus.req_I  = 3'b000;
        bus.lock_I = 3'b000;
    endtask

    task automatic test_uart_write;
        bus.req_I           = 3'b100;
        bus.we_n_I          = 3'b011;
        bus.address_I[2]    = 18'h3FFFF;
        bus.write_data_I[2] = 16'h1234;
        #4;
        tests_run++; if (bus.gnt_O !== 3'b100) begin tests_failed++; $display("FAIL wr_gnt got %b want 100", bus.gnt_O); end
        step;
        bus.req_I  = 3'b000;
        bus.we_n_I = 3'b111;
        #4;
        tests_run++; if (sram_addr !== 18'h3FFFF) begin tests_failed++; $display("FAIL wr_addr got %h want 3ffff", sram_addr); end
        tests_run++; if (sram_wdata !== 16'h1234) begin tests_failed++; $display("FAIL wr_data got %h want 1234", sram_wdata); end
        tests_run++; if (sram_we_n !== 1'b0) begin tests_failed++; $display("FAIL wr_we_n got %b want 0", sram_we_n); end
        step;
        #4;
        tests_run++; if (sram_we_n !== 1'b1) begin tests_failed++; $display("FAIL idle_we_n got %b want 1", sram_we_n); end
        tests_run++; if (sram_addr !== 18'h3FFFF) begin tests_failed++; $display("FAIL idle_addr_hold got %h want 3ffff", sram_addr); end
        for (int k = 0; k < 4; k++) begin
            tests_run++; if (bus.rdata_valid_O !== 3'b000) begin tests_failed++; $display("FAIL wr_no_rvalid[%0d] got %b want 000", k, bus.rdata_valid_O); end
            step;
            #4;
        end
        step;
    endtask

    task automatic test_reset_mid;
        bus.req_I        = 3'b001;
        bus.we_n_I       = 3'b111;
        bus.address_I[0] = 18'h00055;
        #4;
        tests_run++; if (bus.gnt_O !== 3'b001) begin tests_failed++; $display("FAIL rm_gnt got %b want 001", bus.gnt_O); end
        step;
        bus.req_I = 3'b000;
        #4;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rm_busy_inflight got %b want 1", busy); end
        step;
        rst_n = 1'b0;
        #4;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rm_busy_reset got %b want 0", busy); end
        tests_run++; if (sram_addr !== 18'h00000) begin tests_failed++; $display("FAIL rm_addr_reset got %h want 00000", sram_addr); end
        step;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #4;
            tests_run++; if (bus.rdata_valid_O !== 3'b000) begin tests_failed++; $display("FAIL rm_no_rvalid[%0d] got %b want 000", k, bus.rdata_valid_O); end
            step;
        end
    endtask

    task automatic test_back_to_back;
        bus.address_I[0] = 18'h00011;
        bus.address_I[1] = 18'h00022;
        bus.address_I[2] = 18'h00033;
        bus.we_n_I       = 3'b111;
        bus.req_I        = 3'b111;
        #4;
        tests_run++; if (bus.gnt_O !== 3'b001) begin tests_failed++; $display("FAIL b2b_gnt0 got %b want 001", bus.gnt_O); end
        step;
        bus.req_I = 3'b110;
        #4;
        tests_run++; if (bus.gnt_O !== 3'b010) begin tests_failed++; $display("FAIL b2b_gnt1 got %b want 010", bus.gnt_O); end
        tests_run++; if (sram_addr !== 18'h00011) begin tests_failed++; $display("FAIL b2b_addr0 got %h want 00011", sram_addr); end
        step;
        #4;
        tests_run++; if (bus.gnt_O !== 3'b100) begin tests_failed++; $display("FAIL b2b_gnt2 got %b want 100", bus.gnt_O); end
        tests_run++; if (sram_addr !== 18'h00022) begin tests_failed++; $display("FAIL b2b_addr1 got %h want 00022", sram_addr); end
        step;
        bus.req_I = 3'b000;
        #4;
        tests_run++; if (sram_addr !== 18'h00033) begin tests_failed++; $display("FAIL b2b_addr2 got %h want 00033", sram_addr); end
        tests_run++; if (bus.gnt_O !== 3'b000) begin tests_failed++; $display("FAIL b2b_nogrant got %b want 000", bus.gnt_O); end
        repeat (6) step;
    endtask

    initial begin
        tests_run           = 0;
        tests_failed        = 0;
        rst_n               = 1'b0;
        sram_rdata          = 16'h0000;
        bus.req_I           = 3'b000;
        bus.lock_I          = 3'b000;
        bus.we_n_I          = 3'b111;
        bus.address_I       = '0;
        bus.write_data_I    = '0;
        test_reset;
        test_round_robin;
        test_read_latency;
        test_lock_burst;
        test_uart_write;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
